// File: rtl/stat_pkg.sv
// Shared types, widths and the saturating edit helper for the player-stat block.
package stat_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, BUFF = 2'd1, COOL = 2'd2} buff_state_t;

   localparam int ATK_W = 5;
   localparam int SPD_W = 3;
   localparam int TMR_W = 32;

   // One saturating step: +1 up to i_max, -1 down to zero, both or neither = hold.
   function automatic logic [ATK_W-1:0] sat_step(
      input logic [ATK_W-1:0] i_val,
      input logic [ATK_W-1:0] i_max,
      input logic             i_inc,
      input logic             i_dec
   );
      logic [ATK_W-1:0] v_res;
      v_res = i_val;
      if (i_inc && !i_dec) begin
         if (i_val >= i_max) v_res = i_max;
         else                v_res = i_val + 5'd1;
      end else if (i_dec && !i_inc) begin
         if (i_val == 5'd0) v_res = 5'd0;
         else               v_res = i_val - 5'd1;
      end else begin
         v_res = i_val;
      end
      return v_res;
   endfunction

endpackage

// File: rtl/stat_controller_key_edge_sync.sv
// Two-flop synchronizer for an asynchronous key level, with a one-cycle rising-edge pulse.
module key_edge_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // Synchronizer chain plus previous-value flop for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/stat_controller.sv
// Player attack/speed registers with key-driven saturating edits and a timed attack buff
// followed by a cooldown; feeds the seven-segment display stage.
module stat_controller #(
   parameter int unsigned ATK_INIT    = 5,
   parameter int unsigned SPD_INIT    = 1,
   parameter int unsigned ATK_MAX     = 31,
   parameter int unsigned SPD_MAX     = 7,
   parameter int unsigned BUFF_BONUS  = 8,
   parameter int unsigned BUFF_CYCLES = 50_000_000,
   parameter int unsigned COOL_CYCLES = 100_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_key_inc,
   input  logic       i_key_dec,
   input  logic       i_sel,
   input  logic       i_lock,
   input  logic       i_buff_start,
   output logic [4:0] o_attack,
   output logic [2:0] o_speed,
   output logic       o_buff_active,
   output logic       o_cooldown
);
   import stat_pkg::*;

   localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
   localparam logic [TMR_W-1:0] BUFF_LOAD = TMR_W'(BUFF_CYCLES - 32'd1);
   localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOL_CYCLES - 32'd1);

   logic              w_inc_pulse;
   logic              w_dec_pulse;
   buff_state_t       r_state;
   buff_state_t       w_state_nxt;
   logic [TMR_W-1:0]  r_timer;
   logic [TMR_W-1:0]  w_timer_nxt;
   logic [ATK_W-1:0]  r_base_atk;
   logic [SPD_W-1:0]  r_base_spd;
   logic [ATK_W:0]    w_boost_sum;

   key_edge_sync u_inc_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key   (i_key_inc),
      .o_pulse (w_inc_pulse)
   );

   key_edge_sync u_dec_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key   (i_key_dec),
      .o_pulse (w_dec_pulse)
   );

   // Base stat registers; a pulse seen while locked is simply lost.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_base_atk <= ATK_W'(ATK_INIT);
         r_base_spd <= SPD_W'(SPD_INIT);
      end else if (!i_lock && (w_inc_pulse ^ w_dec_pulse)) begin
         if (i_sel) begin
            r_base_spd <= SPD_W'(sat_step(ATK_W'(r_base_spd), ATK_W'(SPD_MAX),
                                          w_inc_pulse, w_dec_pulse));
         end else begin
            r_base_atk <= sat_step(r_base_atk, ATK_W'(ATK_MAX), w_inc_pulse, w_dec_pulse);
         end
      end
   end

   // Buff FSM state and shared down-counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_timer <= TMR_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // Next-state logic: the timer is loaded with length-1 so each phase lasts its full count.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      case (r_state)
         IDLE: begin
            if (i_buff_start) begin
               w_state_nxt = BUFF;
               w_timer_nxt = BUFF_LOAD;
            end else begin
               w_timer_nxt = TMR_ZERO;
            end
         end
         BUFF: begin
            if (r_timer == TMR_ZERO) begin
               w_state_nxt = COOL;
               w_timer_nxt = COOL_LOAD;
            end else begin
               w_timer_nxt = r_timer - TMR_ONE;
            end
         end
         COOL: begin
            if (r_timer == TMR_ZERO) begin
               w_state_nxt = IDLE;
            end else begin
               w_timer_nxt = r_timer - TMR_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_timer_nxt = TMR_ZERO;
         end
      endcase
   end

   // Boosted attack is summed one bit wider so the ceiling check sees the carry.
   always_comb begin
      w_boost_sum = {1'b0, r_base_atk} + (ATK_W+1)'(BUFF_BONUS);
      if (r_state == BUFF) begin
         if (w_boost_sum > (ATK_W+1)'(ATK_MAX)) o_attack = ATK_W'(ATK_MAX);
         else                                   o_attack = w_boost_sum[ATK_W-1:0];
      end else begin
         o_attack = r_base_atk;
      end
   end

   assign o_speed       = r_base_spd;
   assign o_buff_active = (r_state == BUFF);
   assign o_cooldown    = (r_state == COOL);

endmodule

// File: tb/tb_stat_controller.sv
// Directed + randomized bench for stat_controller against a press-level behavioural model.
module tb_stat_controller;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       key_inc    = 1'b0;
   logic       key_dec    = 1'b0;
   logic       sel        = 1'b0;
   logic       lock       = 1'b0;
   logic       buff_start = 1'b0;
   logic [4:0] attack;
   logic [2:0] speed;
   logic       buff_active;
   logic       cooldown;

   int vectors = 0;
   int fails   = 0;

   // model: base values, phase (0 idle, 1 buff, 2 cool) and cycles left in phase
   int m_atk   = 5;
   int m_spd   = 1;
   int m_phase = 0;
   int m_cnt   = 0;

   stat_controller #(
      .BUFF_CYCLES (4),
      .COOL_CYCLES (3)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_key_inc     (key_inc),
      .i_key_dec     (key_dec),
      .i_sel         (sel),
      .i_lock        (lock),
      .i_buff_start  (buff_start),
      .o_attack      (attack),
      .o_speed       (speed),
      .o_buff_active (buff_active),
      .o_cooldown    (cooldown)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_atk();
      if (m_phase == 1) return (m_atk + 8 > 31) ? 31 : m_atk + 8;
      return m_atk;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".attack"}, 32'(attack),      32'(exp_atk()));
      chk({tag, ".speed"},  32'(speed),       32'(m_spd));
      chk({tag, ".buff"},   32'(buff_active), 32'(m_phase == 1));
      chk({tag, ".cool"},   32'(cooldown),    32'(m_phase == 2));
   endtask

   // One clock; model advances the buff/cooldown phase by one cycle.
   task automatic tick();
      logic st;
      st = buff_start;
      @(posedge clk);
      if (rst_n) begin
         if (m_phase == 0) begin
            if (st) begin
               m_phase = 1;
               m_cnt   = 4;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) begin
               if (m_phase == 1) begin
                  m_phase = 2;
                  m_cnt   = 3;
               end else begin
                  m_phase = 0;
               end
            end
         end
      end
      #2;
   endtask

   task automatic press(input logic inc, input logic dec, input logic s,
                        input logic lk, input int hold);
      sel     = s;
      lock    = lk;
      key_inc = inc;
      key_dec = dec;
      tick();
      check_all("press_e0");
      tick();
      check_all("press_e1");
      tick();
      if (!lk) begin
         if (inc && !dec) begin
            if (s) m_spd = (m_spd + 1 > 7) ? 7 : m_spd + 1;
            else   m_atk = (m_atk + 1 > 31) ? 31 : m_atk + 1;
         end else if (dec && !inc) begin
            if (s) m_spd = (m_spd == 0) ? 0 : m_spd - 1;
            else   m_atk = (m_atk == 0) ? 0 : m_atk - 1;
         end
      end
      check_all("press_e2");
      for (int h = 0; h < hold; h++) begin
         tick();
         check_all("press_hold");
      end
      key_inc = 1'b0;
      key_dec = 1'b0;
      for (int r = 0; r < 3; r++) begin
         tick();
         check_all("press_rel");
      end
      lock = 1'b0;
   endtask

   task automatic do_reset();
      key_inc    = 1'b0;
      key_dec    = 1'b0;
      buff_start = 1'b0;
      rst_n      = 1'b0;
      #1;
      m_atk   = 5;
      m_spd   = 1;
      m_phase = 0;
      m_cnt   = 0;
      check_all("reset_async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // 1. reset
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      tick();
      check_all("reset_rel");

      // 2. latency, single edit while held
      press(1'b1, 1'b0, 1'b0, 1'b0, 10);
      chk("inc_held_once", 32'(attack), 32'd6);

      // 3. speed saturation both ways
      repeat (8) press(1'b0, 1'b1, 1'b1, 1'b0, 0);
      chk("spd_floor", 32'(speed), 32'd0);
      repeat (10) press(1'b1, 1'b0, 1'b1, 1'b0, 0);
      chk("spd_ceiling", 32'(speed), 32'd7);

      // 4. simultaneous keys and lock
      press(1'b1, 1'b1, 1'b0, 1'b0, 0);
      press(1'b1, 1'b1, 1'b1, 1'b0, 1);
      press(1'b1, 1'b0, 1'b0, 1'b1, 0);
      press(1'b0, 1'b1, 1'b1, 1'b1, 2);
      tick();
      check_all("after_lock");

      // randomized presses
      for (int k = 0; k < 24; k++) begin
         press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 2)));
      end

      // 5. buff timing with saturation, ignored start in cooldown
      while (m_atk < 28) press(1'b1, 1'b0, 1'b0, 1'b0, 0);
      while (m_atk > 28) press(1'b0, 1'b1, 1'b0, 1'b0, 0);
      buff_start = 1'b1;
      tick();
      buff_start = 1'b0;
      check_all("buff_c0");
      chk("buff_sat", 32'(attack), 32'd31);
      repeat (4) begin
         tick();
         check_all("buff_run");
      end
      chk("cool_atk", 32'(attack), 32'd28);
      buff_start = 1'b1;
      tick();
      buff_start = 1'b0;
      check_all("cool_start_ign");
      repeat (3) begin
         tick();
         check_all("cool_run");
      end
      chk("idle_after", 32'(cooldown), 32'd0);

      // 6. edit during buff, then reset mid-buff
      do_reset();
      buff_start = 1'b1;
      tick();
      buff_start = 1'b0;
      chk("buff_13", 32'(attack), 32'd13);
      press(1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (8) begin
         tick();
         check_all("wait_idle");
      end
      buff_start = 1'b1;
      tick();
      buff_start = 1'b0;
      tick();
      check_all("buff_again");
      chk("buff_14", 32'(attack), 32'd14);
      do_reset();
      chk("rst_mid_atk", 32'(attack), 32'd5);
      chk("rst_mid_buff", 32'(buff_active), 32'd0);
      tick();
      check_all("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
